spider_controller: RTL and testbench

//  Frame-rate controller for the single spider enemy. Sequences spawn, zig-zag descent, hit/death

---
 rtl/spider_controller_pkg.sv | 25 ++
 rtl/spider_controller_if.sv | 28 ++
 rtl/spider_motion_step.sv | 53 +++++
 rtl/spider_controller.sv | 135 +++++++++++++
 tb/tb_spider_controller.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spider_controller_pkg.sv
// Shared definitions for the spider enemy: FSM state codes, playfield geometry,
// direction encoding and the motion state record passed between controller and stepper.
package spider_controller_pkg;

    localparam logic [1:0] ST_WAIT  = 2'd0;
    localparam logic [1:0] ST_MOVE  = 2'd1;
    localparam logic [1:0] ST_DYING = 2'd2;

    localparam int SCREEN_W_DEF    = 640;
    localparam int SPRITE_SIZE_DEF = 32;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       dir;
    } motion_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spider_controller_if.sv
// Game-logic side of the spider controller: frame/enable/hit inputs and the
// registered sprite, event and state outputs.
interface spider_controller_if;

    logic       frame_tick;
    logic       enable;
    logic       hit;
    logic [9:0] spider_x;
    logic [9:0] spider_y;
    logic       spider_alive;
    logic       spider_flash;
    logic       kill_pulse;
    logic       escape_pulse;
    logic [1:0] state;

    modport master (
        output frame_tick, enable, hit,
        input  spider_x, spider_y, spider_alive, spider_flash,
        input  kill_pulse, escape_pulse, state
    );

    modport slave (
        input  frame_tick, enable, hit,
        output spider_x, spider_y, spider_alive, spider_flash,
        output kill_pulse, escape_pulse, state
    );

endinterface

// File: rtl/spider_motion_step.sv
// One frame of zig-zag motion: horizontal step with wall clamp/bounce, vertical
// step, and a floor-reached flag. Purely combinational.
module spider_motion_step
    import spider_controller_pkg::*;
#(
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int SPRITE_SIZE = SPRITE_SIZE_DEF,
    parameter int FLOOR_Y     = 416,
    parameter int STEP_X      = 4,
    parameter int STEP_Y      = 1
) (
    input  motion_t cur,
    output motion_t nxt,
    output logic    at_floor
);

    localparam logic signed [10:0] MAX_X   = 11'(SCREEN_W - SPRITE_SIZE);
    localparam logic signed [10:0] STEP_XS = 11'(STEP_X);
    localparam logic [10:0]        STEP_YS = 11'(STEP_Y);
    localparam logic [10:0]        FLOOR   = 11'(FLOOR_Y);

    logic signed [10:0] x_s;
    logic signed [10:0] nx_s;
    logic [10:0]        ny_w;

    always_comb begin
        nxt  = cur;
        x_s  = signed'({1'b0, cur.x});
        nx_s = x_s;
        // Signed math so a left step past the wall shows up as <= 0 instead of wrapping.
        if (cur.dir == DIR_RIGHT) begin
            nx_s = x_s + STEP_XS;
            if (nx_s >= MAX_X) begin
                nxt.x   = MAX_X[9:0];
                nxt.dir = DIR_LEFT;
            end else begin
                nxt.x = nx_s[9:0];
            end
        end else begin
            nx_s = x_s - STEP_XS;
            if (nx_s <= 11'sd0) begin
                nxt.x   = 10'd0;
                nxt.dir = DIR_RIGHT;
            end else begin
                nxt.x = nx_s[9:0];
            end
        end
        ny_w     = {1'b0, cur.y} + STEP_YS;
        nxt.y    = ny_w[9:0];
        at_floor = (ny_w >= FLOOR);
    end

endmodule

// File: rtl/spider_controller.sv
// Spider enemy sequencer: respawn delay, zig-zag descent, hit flash and escape,
// all advanced by the gated frame tick. Every output comes straight from a register.
module spider_controller
    import spider_controller_pkg::*;
#(
    parameter int SCREEN_W       = SCREEN_W_DEF,
    parameter int SPRITE_SIZE    = SPRITE_SIZE_DEF,
    parameter int SPAWN_X        = 0,
    parameter int SPAWN_Y        = 32,
    parameter int FLOOR_Y        = 416,
    parameter int STEP_X         = 4,
    parameter int STEP_Y         = 1,
    parameter int RESPAWN_FRAMES = 120,
    parameter int DYING_FRAMES   = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    spider_controller_if.slave  bus
);

    // At least two bits so the flash tap (bit 1) always exists.
    localparam int CNT_W = max_int($clog2(max_int(RESPAWN_FRAMES, DYING_FRAMES) + 1), 2);
    localparam logic [CNT_W-1:0] RESPAWN_CNT = CNT_W'(RESPAWN_FRAMES);
    localparam logic [CNT_W-1:0] DYING_CNT   = CNT_W'(DYING_FRAMES);
    localparam motion_t          SPAWN_POS   = '{x: 10'(SPAWN_X), y: 10'(SPAWN_Y), dir: DIR_RIGHT};

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_dec;
    motion_t          pos_reg, pos_next, step_pos;
    logic             alive_reg, alive_next;
    logic             flash_reg, flash_next;
    logic             kill_reg, kill_next;
    logic             escape_reg, escape_next;
    logic             tick, hit_v, at_floor;

    assign tick    = bus.frame_tick & bus.enable;
    assign hit_v   = bus.hit & bus.enable;
    assign cnt_dec = cnt_reg - 1'b1;

    spider_motion_step #(
        .SCREEN_W    (SCREEN_W),
        .SPRITE_SIZE (SPRITE_SIZE),
        .FLOOR_Y     (FLOOR_Y),
        .STEP_X      (STEP_X),
        .STEP_Y      (STEP_Y)
    ) u_step (
        .cur      (pos_reg),
        .nxt      (step_pos),
        .at_floor (at_floor)
    );

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        pos_next    = pos_reg;
        alive_next  = alive_reg;
        flash_next  = flash_reg;
        kill_next   = 1'b0;
        escape_next = 1'b0;
        case (state_reg)
            ST_MOVE: begin
                // A hit wins over a same-cycle tick, so the sprite dies where it was drawn.
                if (hit_v) begin
                    kill_next  = 1'b1;
                    cnt_next   = DYING_CNT;
                    flash_next = DYING_CNT[1];
                    state_next = ST_DYING;
                end else if (tick) begin
                    pos_next = step_pos;
                    if (at_floor) begin
                        escape_next = 1'b1;
                        alive_next  = 1'b0;
                        cnt_next    = RESPAWN_CNT;
                        state_next  = ST_WAIT;
                    end
                end
            end
            ST_DYING: begin
                if (tick) begin
                    if (cnt_reg <= CNT_W'(1)) begin
                        alive_next = 1'b0;
                        flash_next = 1'b0;
                        cnt_next   = RESPAWN_CNT;
                        state_next = ST_WAIT;
                    end else begin
                        cnt_next   = cnt_dec;
                        flash_next = cnt_dec[1];
                    end
                end
            end
            default: begin
                // WAIT, and the unused code 3 behaves the same way.
                if (tick) begin
                    if (cnt_reg <= CNT_W'(1)) begin
                        pos_next   = SPAWN_POS;
                        alive_next = 1'b1;
                        flash_next = 1'b0;
                        state_next = ST_MOVE;
                    end else begin
                        cnt_next = cnt_dec;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_WAIT;
            cnt_reg    <= RESPAWN_CNT;
            pos_reg    <= SPAWN_POS;
            alive_reg  <= 1'b0;
            flash_reg  <= 1'b0;
            kill_reg   <= 1'b0;
            escape_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            pos_reg    <= pos_next;
            alive_reg  <= alive_next;
            flash_reg  <= flash_next;
            kill_reg   <= kill_next;
            escape_reg <= escape_next;
        end
    end

    assign bus.spider_x     = pos_reg.x;
    assign bus.spider_y     = pos_reg.y;
    assign bus.spider_alive = alive_reg;
    assign bus.spider_flash = flash_reg;
    assign bus.kill_pulse   = kill_reg;
    assign bus.escape_pulse = escape_reg;
    assign bus.state        = state_reg;

endmodule

// File: tb/tb_spider_controller.sv
// Directed bench for spider_controller with short respawn/dying delays.
module tb_spider_controller;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    // Bench-side expectation of the sprite position while moving.
    int   exp_x, exp_y;
    bit   exp_left;

    spider_controller_if bus_if ();

    spider_controller #(
        .RESPAWN_FRAMES (3),
        .DYING_FRAMES   (4),
        .STEP_X         (4),
        .STEP_Y         (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic do_tick();
        @(negedge clk);
        bus_if.frame_tick = 1'b1;
        @(negedge clk);
        bus_if.frame_tick = 1'b0;
    endtask

    task automatic move_tick();
        do_tick();
        if (!exp_left) begin
            exp_x = exp_x + 4;
            if (exp_x >= 608) begin exp_x = 608; exp_left = 1'b1; end
        end else begin
            exp_x = exp_x - 4;
            if (exp_x <= 0) begin exp_x = 0; exp_left = 1'b0; end
        end
        exp_y = exp_y + 1;
    endtask

    task automatic test_reset();
        total++;
        if (bus_if.state !== 2'd0 || bus_if.spider_alive !== 1'b0 || bus_if.spider_flash !== 1'b0) begin
            bad++; $display("FAIL reset_state: state=%0d alive=%0b flash=%0b, want 0/0/0",
                            bus_if.state, bus_if.spider_alive, bus_if.spider_flash);
        end
        total++;
        if (bus_if.spider_x !== 10'd0 || bus_if.spider_y !== 10'd32) begin
            bad++; $display("FAIL reset_pos: x=%0d y=%0d, want 0/32", bus_if.spider_x, bus_if.spider_y);
        end
        total++;
        if (bus_if.kill_pulse !== 1'b0 || bus_if.escape_pulse !== 1'b0) begin
            bad++; $display("FAIL reset_pulses: kill=%0b esc=%0b, want 0/0", bus_if.kill_pulse, bus_if.escape_pulse);
        end
        $display("reset: state=%0d x=%0d y=%0d", bus_if.state, bus_if.spider_x, bus_if.spider_y);
    endtask

    task automatic test_spawn();
        for (int i = 1; i <= 3; i++) begin
            do_tick();
            total++;
            if (bus_if.spider_alive !== (i == 3) || bus_if.state !== ((i == 3) ? 2'd1 : 2'd0)) begin
                bad++; $display("FAIL spawn_tick%0d: alive=%0b state=%0d, want %0b/%0d",
                                i, bus_if.spider_alive, bus_if.state, (i == 3), (i == 3) ? 1 : 0);
            end
            total++;
            if (bus_if.kill_pulse !== 1'b0 || bus_if.escape_pulse !== 1'b0) begin
                bad++; $display("FAIL spawn_pulses%0d: kill=%0b esc=%0b, want 0/0", i, bus_if.kill_pulse, bus_if.escape_pulse);
            end
        end
        total++;
        if (bus_if.spider_x !== 10'd0 || bus_if.spider_y !== 10'd32) begin
            bad++; $display("FAIL spawn_pos: x=%0d y=%0d, want 0/32", bus_if.spider_x, bus_if.spider_y);
        end
        exp_x = 0; exp_y = 32; exp_left = 1'b0;
        $display("spawn: state=%0d x=%0d y=%0d", bus_if.state, bus_if.spider_x, bus_if.spider_y);
    endtask

    task automatic test_bounce_right();
        int want_x[4] = '{600, 604, 608, 604};
        int want_y[4] = '{182, 183, 184, 185};
        repeat (150) move_tick();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) move_tick();
            total++;
            if (bus_if.spider_x !== 10'(want_x[i]) || bus_if.spider_y !== 10'(want_y[i])) begin
                bad++; $display("FAIL bounce_right%0d: x=%0d y=%0d, want %0d/%0d",
                                i, bus_if.spider_x, bus_if.spider_y, want_x[i], want_y[i]);
            end
            $display("bounce_right: x=%0d y=%0d", bus_if.spider_x, bus_if.spider_y);
        end
    endtask

    task automatic test_bounce_left();
        int want_x[3] = '{4, 0, 4};
        int want_y[3] = '{335, 336, 337};
        repeat (150) move_tick();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) move_tick();
            total++;
            if (bus_if.spider_x !== 10'(want_x[i]) || bus_if.spider_y !== 10'(want_y[i])) begin
                bad++; $display("FAIL bounce_left%0d: x=%0d y=%0d, want %0d/%0d",
                                i, bus_if.spider_x, bus_if.spider_y, want_x[i], want_y[i]);
            end
            $display("bounce_left: x=%0d y=%0d", bus_if.spider_x, bus_if.spider_y);
        end
    endtask

    task automatic test_kill();
        bit want_flash[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        repeat (24) move_tick();
        total++;
        if (bus_if.spider_x !== 10'd100 || bus_if.spider_y !== 10'd361) begin
            bad++; $display("FAIL kill_prepos: x=%0d y=%0d, want 100/361", bus_if.spider_x, bus_if.spider_y);
        end
        @(negedge clk);
        bus_if.hit = 1'b1;
        bus_if.frame_tick = 1'b1;
        @(negedge clk);
        bus_if.frame_tick = 1'b0;
        total++;
        if (bus_if.kill_pulse !== 1'b1 || bus_if.state !== 2'd2 || bus_if.spider_alive !== 1'b1) begin
            bad++; $display("FAIL kill_entry: kill=%0b state=%0d alive=%0b, want 1/2/1",
                            bus_if.kill_pulse, bus_if.state, bus_if.spider_alive);
        end
        total++;
        if (bus_if.spider_x !== 10'd100 || bus_if.spider_y !== 10'd361 || bus_if.spider_flash !== 1'b0) begin
            bad++; $display("FAIL kill_frozen: x=%0d y=%0d flash=%0b, want 100/361/0",
                            bus_if.spider_x, bus_if.spider_y, bus_if.spider_flash);
        end
        $display("kill: kill=%0b state=%0d x=%0d y=%0d", bus_if.kill_pulse, bus_if.state, bus_if.spider_x, bus_if.spider_y);
        @(negedge clk);
        total++;
        if (bus_if.kill_pulse !== 1'b0) begin
            bad++; $display("FAIL kill_width: kill=%0b, want 0", bus_if.kill_pulse);
        end
        for (int i = 0; i < 4; i++) begin
            do_tick();
            total++;
            if (bus_if.kill_pulse !== 1'b0 || bus_if.spider_flash !== want_flash[i] ||
                bus_if.spider_alive !== (i < 3) || bus_if.state !== ((i < 3) ? 2'd2 : 2'd0)) begin
                bad++; $display("FAIL dying_tick%0d: kill=%0b flash=%0b alive=%0b state=%0d, want 0/%0b/%0b/%0d",
                                i, bus_if.kill_pulse, bus_if.spider_flash, bus_if.spider_alive, bus_if.state,
                                want_flash[i], (i < 3), (i < 3) ? 2 : 0);
            end
            $display("dying: tick=%0d flash=%0b alive=%0b state=%0d", i, bus_if.spider_flash, bus_if.spider_alive, bus_if.state);
        end
        bus_if.hit = 1'b0;
        repeat (3) do_tick();
        total++;
        if (bus_if.state !== 2'd1 || bus_if.spider_x !== 10'd0 || bus_if.spider_y !== 10'd32) begin
            bad++; $display("FAIL kill_respawn: state=%0d x=%0d y=%0d, want 1/0/32", bus_if.state, bus_if.spider_x, bus_if.spider_y);
        end
        exp_x = 0; exp_y = 32; exp_left = 1'b0;
    endtask

    task automatic test_enable();
        bus_if.enable = 1'b0;
        bus_if.hit = 1'b1;
        repeat (3) do_tick();
        total++;
        if (bus_if.state !== 2'd1 || bus_if.spider_x !== 10'd0 || bus_if.spider_y !== 10'd32 ||
            bus_if.spider_alive !== 1'b1 || bus_if.kill_pulse !== 1'b0) begin
            bad++; $display("FAIL enable_freeze: state=%0d x=%0d y=%0d alive=%0b kill=%0b, want 1/0/32/1/0",
                            bus_if.state, bus_if.spider_x, bus_if.spider_y, bus_if.spider_alive, bus_if.kill_pulse);
        end
        bus_if.hit = 1'b0;
        bus_if.enable = 1'b1;
        move_tick();
        total++;
        if (bus_if.spider_x !== 10'd4 || bus_if.spider_y !== 10'd33) begin
            bad++; $display("FAIL enable_resume: x=%0d y=%0d, want 4/33", bus_if.spider_x, bus_if.spider_y);
        end
        $display("enable: resumed x=%0d y=%0d", bus_if.spider_x, bus_if.spider_y);
    endtask

    task automatic test_escape();
        repeat (382) move_tick();
        total++;
        if (bus_if.spider_y !== 10'd415 || bus_if.state !== 2'd1) begin
            bad++; $display("FAIL escape_pre: y=%0d state=%0d, want 415/1", bus_if.spider_y, bus_if.state);
        end
        move_tick();
        total++;
        if (bus_if.spider_y !== 10'd416 || bus_if.escape_pulse !== 1'b1 || bus_if.spider_alive !== 1'b0 ||
            bus_if.state !== 2'd0 || bus_if.kill_pulse !== 1'b0) begin
            bad++; $display("FAIL escape_entry: y=%0d esc=%0b alive=%0b state=%0d kill=%0b, want 416/1/0/0/0",
                            bus_if.spider_y, bus_if.escape_pulse, bus_if.spider_alive, bus_if.state, bus_if.kill_pulse);
        end
        total++;
        if (bus_if.spider_x !== 10'(exp_x)) begin
            bad++; $display("FAIL escape_x: x=%0d, want %0d", bus_if.spider_x, exp_x);
        end
        $display("escape: esc=%0b x=%0d y=%0d", bus_if.escape_pulse, bus_if.spider_x, bus_if.spider_y);
        @(negedge clk);
        total++;
        if (bus_if.escape_pulse !== 1'b0) begin
            bad++; $display("FAIL escape_width: esc=%0b, want 0", bus_if.escape_pulse);
        end
        repeat (3) do_tick();
        total++;
        if (bus_if.state !== 2'd1 || bus_if.spider_x !== 10'd0 || bus_if.spider_y !== 10'd32 || bus_if.spider_alive !== 1'b1) begin
            bad++; $display("FAIL escape_respawn: state=%0d x=%0d y=%0d alive=%0b, want 1/0/32/1",
                            bus_if.state, bus_if.spider_x, bus_if.spider_y, bus_if.spider_alive);
        end
    endtask

    task automatic test_reset_mid_dying();
        @(negedge clk);
        bus_if.hit = 1'b1;
        @(negedge clk);
        bus_if.hit = 1'b0;
        do_tick();
        total++;
        if (bus_if.state !== 2'd2) begin
            bad++; $display("FAIL mid_dying_pre: state=%0d, want 2", bus_if.state);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus_if.state !== 2'd0 || bus_if.spider_alive !== 1'b0 || bus_if.spider_flash !== 1'b0 ||
            bus_if.spider_x !== 10'd0 || bus_if.spider_y !== 10'd32) begin
            bad++; $display("FAIL async_reset: state=%0d alive=%0b flash=%0b x=%0d y=%0d, want 0/0/0/0/32",
                            bus_if.state, bus_if.spider_alive, bus_if.spider_flash, bus_if.spider_x, bus_if.spider_y);
        end
        $display("async_reset: state=%0d x=%0d y=%0d", bus_if.state, bus_if.spider_x, bus_if.spider_y);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus_if.frame_tick = 1'b0;
        bus_if.enable     = 1'b1;
        bus_if.hit        = 1'b0;
        rst_n             = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_spawn();
        test_bounce_right();
        test_bounce_left();
        test_kill();
        test_enable();
        test_escape();
        test_reset_mid_dying();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
